// File: rtl/id_branch_unit.sv
// rtl/id_branch_unit.sv - IF/ID register, field split and branch resolution with one-bubble squash
module id_branch_unit #(
  parameter int ADDR_W = 10,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W+9:0]   iFetchedInst,
  input  logic [ADDR_W-1:0] iNew_pc,
  input  logic [2:0]        iFlagsA,
  input  logic [2:0]        iFlagsB,
  output logic [ADDR_W-1:0] oBr_dir,
  output logic              oBr_taken,
  output logic [OP_W-1:0]   oOpcode,
  output logic [9:0]        oOperand,
  output logic [ADDR_W-1:0] oPc,
  output logic              oValid
);

  // Opcode encodings shared with the instruction set definition.
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'('h20);
  localparam logic [OP_W-1:0] OP_BAEQ = OP_W'('h21);
  localparam logic [OP_W-1:0] OP_BANE = OP_W'('h22);
  localparam logic [OP_W-1:0] OP_BACS = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_BACC = OP_W'('h24);
  localparam logic [OP_W-1:0] OP_BAMI = OP_W'('h25);
  localparam logic [OP_W-1:0] OP_BAPL = OP_W'('h26);
  localparam logic [OP_W-1:0] OP_BBEQ = OP_W'('h27);
  localparam logic [OP_W-1:0] OP_BBNE = OP_W'('h28);
  localparam logic [OP_W-1:0] OP_BBCS = OP_W'('h29);
  localparam logic [OP_W-1:0] OP_BBCC = OP_W'('h2A);
  localparam logic [OP_W-1:0] OP_BBMI = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BBPL = OP_W'('h2C);

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } state_t;

  state_t                state_q, state_d;
  logic [OP_W+9:0]       inst_q, inst_d;
  logic [ADDR_W-1:0]     new_pc_q, new_pc_d;

  logic [OP_W-1:0]       raw_opcode;
  logic [ADDR_W+OP_W+9:0] inst_ext;
  logic                  cond;

  // IF/ID register and state; reset loads a NOP and starts with a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_SQUASH;
      inst_q   <= {OP_NOP, 10'b0};
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Condition evaluation on the registered opcode against the live flags ({N,Z,C}).
  always_comb begin
    cond       = 1'b0;
    raw_opcode = inst_q[OP_W+9:10];
    case (raw_opcode)
      OP_JMP:  cond = 1'b1;
      OP_BAEQ: cond = iFlagsA[1];
      OP_BANE: cond = ~iFlagsA[1];
      OP_BACS: cond = iFlagsA[0];
      OP_BACC: cond = ~iFlagsA[0];
      OP_BAMI: cond = iFlagsA[2];
      OP_BAPL: cond = ~iFlagsA[2];
      OP_BBEQ: cond = iFlagsB[1];
      OP_BBNE: cond = ~iFlagsB[1];
      OP_BBCS: cond = iFlagsB[0];
      OP_BBCC: cond = ~iFlagsB[0];
      OP_BBMI: cond = iFlagsB[2];
      OP_BBPL: cond = ~iFlagsB[2];
      default: cond = 1'b0;
    endcase
  end

  // Next-state and outputs; SQUASH masks the wrong-path instruction after a taken branch.
  always_comb begin
    state_d   = state_q;
    inst_d    = iFetchedInst;
    new_pc_d  = iNew_pc;
    inst_ext  = {{ADDR_W{1'b0}}, inst_q};
    oBr_dir   = inst_ext[ADDR_W-1:0];
    oPc       = new_pc_q - ADDR_W'(1);
    oBr_taken = 1'b0;
    oValid    = 1'b0;
    oOpcode   = OP_NOP;
    oOperand  = 10'b0;
    case (state_q)
      ST_RUN: begin
        oValid    = 1'b1;
        oOpcode   = inst_q[OP_W+9:10];
        oOperand  = inst_q[9:0];
        oBr_taken = cond;
        if (cond) begin
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_SQUASH;
      end
    endcase
  end

endmodule

// File: tb/tb_id_branch_unit.sv
// tb/tb_id_branch_unit.sv - directed self-checking bench for id_branch_unit
module tb_id_branch_unit;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] LDCA = 6'h01;
  localparam logic [5:0] LDCB = 6'h02;
  localparam logic [5:0] JMP  = 6'h20;
  localparam logic [5:0] BANE = 6'h22;
  localparam logic [5:0] BACS = 6'h23;
  localparam logic [5:0] BBEQ = 6'h27;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iFetchedInst;
  logic [9:0]  iNew_pc;
  logic [2:0]  iFlagsA;
  logic [2:0]  iFlagsB;
  logic [9:0]  oBr_dir;
  logic        oBr_taken;
  logic [5:0]  oOpcode;
  logic [9:0]  oOperand;
  logic [9:0]  oPc;
  logic        oValid;

  int total = 0;
  int bad   = 0;

  id_branch_unit #(.ADDR_W(10), .OP_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .iFetchedInst (iFetchedInst),
    .iNew_pc      (iNew_pc),
    .iFlagsA      (iFlagsA),
    .iFlagsB      (iFlagsB),
    .oBr_dir      (oBr_dir),
    .oBr_taken    (oBr_taken),
    .oOpcode      (oOpcode),
    .oOperand     (oOperand),
    .oPc          (oPc),
    .oValid       (oValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] inst, input logic [9:0] npc);
    iFetchedInst = inst;
    iNew_pc      = npc;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 16'(oValid), 16'h0);
    chk({tag, "_taken"}, 16'(oBr_taken), 16'h0);
    chk({tag, "_op"}, 16'(oOpcode), 16'(NOP));
    chk({tag, "_operand"}, 16'(oOperand), 16'h0);
  endtask

  initial begin
    reset   = 1'b0;
    iFlagsA = 3'b000;
    iFlagsB = 3'b000;

    // reset hold with an arbitrary (branch-like) instruction on the fetch port
    for (int i = 0; i < 3; i++) begin
      cyc(16'hABCD, 10'h123);
      chk_bubble("rst");
      chk("rst_pc", 16'(oPc), 16'h3FF);
      chk("rst_dir", 16'(oBr_dir), 16'h000);
    end

    // release; PC 0 is captured at the next edge
    reset = 1'b1;
    cyc({LDCA, 2'b00, 8'h05}, 10'd1);
    chk("s0_op", 16'(oOpcode), 16'(LDCA));
    chk("s0_operand", 16'(oOperand), 16'h005);
    chk("s0_pc", 16'(oPc), 16'd0);
    chk("s0_valid", 16'(oValid), 16'h1);
    chk("s0_taken", 16'(oBr_taken), 16'h0);
    cyc({LDCB, 2'b00, 8'h07}, 10'd2);
    chk("s1_op", 16'(oOpcode), 16'(LDCB));
    chk("s1_operand", 16'(oOperand), 16'h007);
    chk("s1_pc", 16'(oPc), 16'd1);
    chk("s1_valid", 16'(oValid), 16'h1);
    chk("s1_taken", 16'(oBr_taken), 16'h0);

    // taken conditional: carry set on A
    iFlagsA = 3'b001;
    cyc({BACS, 4'b0, 6'd50}, 10'd16);
    chk("bacs_taken", 16'(oBr_taken), 16'h1);
    chk("bacs_dir", 16'(oBr_dir), 16'd50);
    chk("bacs_pc", 16'(oPc), 16'd15);
    cyc({LDCA, 10'h011}, 10'd17);
    chk_bubble("bacs_sq");
    cyc({LDCB, 10'h022}, 10'd51);
    chk("bacs_tgt_pc", 16'(oPc), 16'd50);
    chk("bacs_tgt_valid", 16'(oValid), 16'h1);
    chk("bacs_tgt_op", 16'(oOpcode), 16'(LDCB));

    // not-taken conditional: no bubble
    iFlagsA = 3'b000;
    cyc({BACS, 4'b0, 6'd50}, 10'd16);
    chk("bacc_taken", 16'(oBr_taken), 16'h0);
    chk("bacc_valid", 16'(oValid), 16'h1);
    cyc({LDCA, 10'h033}, 10'd17);
    chk("bacc_next_pc", 16'(oPc), 16'd16);
    chk("bacc_next_valid", 16'(oValid), 16'h1);
    chk("bacc_next_op", 16'(oOpcode), 16'(LDCA));

    // flag sensitivity while the branch sits in decode (left untaken at the edge)
    cyc({BBEQ, 10'h0AA}, 10'd18);
    iFlagsB = 3'b010; #1;
    chk("bbeq_z1", 16'(oBr_taken), 16'h1);
    iFlagsB = 3'b101; #1;
    chk("bbeq_z0", 16'(oBr_taken), 16'h0);
    cyc({BANE, 10'h0BB}, 10'd19);
    chk("bbeq_nobubble", 16'(oValid), 16'h1);
    iFlagsA = 3'b010; #1;
    chk("bane_z1", 16'(oBr_taken), 16'h0);
    iFlagsA = 3'b000; #1;
    chk("bane_z0", 16'(oBr_taken), 16'h1);
    chk("bane_dir", 16'(oBr_dir), 16'h0BB);
    iFlagsA = 3'b010;
    iFlagsB = 3'b000;

    // squash ignores a JMP in the wrong-path slot
    cyc({JMP, 10'h040}, 10'd21);
    chk("j1_taken", 16'(oBr_taken), 16'h1);
    chk("j1_dir", 16'(oBr_dir), 16'h040);
    cyc({JMP, 10'h020}, 10'd22);
    chk_bubble("j1_sq");
    cyc({LDCA, 10'h044}, 10'h041);
    chk("j1_tgt_pc", 16'(oPc), 16'h040);
    chk("j1_tgt_op", 16'(oOpcode), 16'(LDCA));
    chk("j1_tgt_taken", 16'(oBr_taken), 16'h0);

    // back-to-back taken branches across the address wrap
    cyc({JMP, 10'h3FF}, 10'h042);
    chk("w1_taken", 16'(oBr_taken), 16'h1);
    chk("w1_dir", 16'(oBr_dir), 16'h3FF);
    cyc({LDCB, 10'h055}, 10'h043);
    chk_bubble("w1_sq");
    cyc({JMP, 10'h000}, 10'h000);
    chk("w2_pc", 16'(oPc), 16'h3FF);
    chk("w2_taken", 16'(oBr_taken), 16'h1);
    chk("w2_dir", 16'(oBr_dir), 16'h000);
    cyc({LDCA, 10'h066}, 10'h001);
    chk_bubble("w2_sq");
    cyc({LDCB, 10'h077}, 10'h001);
    chk("w2_tgt_pc", 16'(oPc), 16'h000);
    chk("w2_tgt_valid", 16'(oValid), 16'h1);

    // reset asserted while a taken branch is in decode
    cyc({JMP, 10'h100}, 10'h002);
    chk("r_taken", 16'(oBr_taken), 16'h1);
    reset = 1'b0;
    cyc({LDCA, 10'h088}, 10'h003);
    chk_bubble("r_after");
    chk("r_pc", 16'(oPc), 16'h3FF);
    chk("r_dir", 16'(oBr_dir), 16'h000);
    reset = 1'b1;
    cyc({LDCA, 10'h099}, 10'h001);
    chk("r_rel_pc", 16'(oPc), 16'h000);
    chk("r_rel_valid", 16'(oValid), 16'h1);
    chk("r_rel_operand", 16'(oOperand), 16'h099);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_branch_unit.md
# id_branch_unit

Instruction-decode stage that sits directly downstream of `iFetch`. It captures `oFetchedInst`/`oNew_pc` into an IF/ID register and splits the instruction into opcode and operand fields for the execute stage. It resolves jumps and conditional branches against the A/B condition flags, and drives `iBr_dir`/`iBr_taken` back into fetch. It squashes the single wrong-path instruction that fetch delivers after every taken branch.

## Interface
- `ADDR_W`, 10: instruction-address width; equals `LENGTH_INSTR_MEM`.
- `OP_W`, 6: opcode width; instruction width is `OP_W+10`, which equals `WIDTH_INSTR_MEM`.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`.
- `iFetchedInst` in `OP_W+10`: instruction from fetch.
- `iNew_pc` in `ADDR_W`: address of `iFetchedInst` plus 1, from fetch.
- `iFlagsA` in 3: {N,Z,C} of accumulator A, from execute.
- `iFlagsB` in 3: {N,Z,C} of accumulator B, from execute.
- `oBr_dir` out `ADDR_W`: branch target; connects to fetch `iBr_dir`.
- `oBr_taken` out 1: branch taken; connects to fetch `iBr_taken`.
- `oOpcode` out `OP_W`: decoded opcode to execute; `NOP` when squashed.
- `oOperand` out 10: operand field; 0 when squashed.
- `oPc` out `ADDR_W`: address of the instruction currently in decode.
- `oValid` out 1: high when `oOpcode`/`oOperand` hold a real instruction.

## Operation
- IF/ID register:
  - Every posedge with `reset`=1, it loads `rInst`←`iFetchedInst` and `rNewPc`←`iNew_pc`.
  - There is no stall; a new instruction is taken every cycle.
- Field split:
  - `oOpcode` = `rInst[OP_W+9:10]`.
  - `oOperand` = `rInst[9:0]`.
  - `oPc` = `rNewPc - 1`, computed modulo 2^`ADDR_W`.
- Branch target: `oBr_dir` = `rInst[ADDR_W-1:0]`. This is an absolute address, zero-extended or truncated to `ADDR_W`. It is driven continuously, whether or not a branch is taken.
- Branch condition, with opcodes from `instrDefine.v`:
  - `JMP`: always taken.
  - `BAEQ`/`BANE`: taken when A.Z = 1 / A.Z = 0.
  - `BACS`/`BACC`: taken when A.C = 1 / A.C = 0.
  - `BAMI`/`BAPL`: taken when A.N = 1 / A.N = 0.
  - `BBxx`: the same six conditions evaluated on `iFlagsB`.
  - Any other opcode: never taken.
- `oBr_taken` = condition true AND state = RUN.
- State machine, 2 states:
  - RUN: the decode register holds a valid instruction; `oValid`=1.
    - `oBr_taken`=1 → SQUASH at the next edge.
    - Otherwise stay in RUN.
  - SQUASH: the decode register holds the wrong-path instruction fetched at `taken_addr+1`.
    - Force `oOpcode`=`NOP`, `oOperand`=0, `oValid`=0, `oBr_taken`=0.
    - Always go to RUN at the next edge.
- A branch opcode sitting in decode during SQUASH is ignored.
- A branch located at the target address is resolved normally in the following RUN cycle, so back-to-back taken branches are supported.
- Flags are sampled combinationally in the cycle the branch is in decode; no internal flag forwarding or interlock. Software separates flag-setting instructions from dependent branches with `NOP`s.

## Timing
- Reset (posedge with `reset`=0):
  - `rInst`←{`NOP`,10'b0}, `rNewPc`←0, state←SQUASH.
  - The first cycle after reset release is therefore a bubble while fetch's PC settles to 0.
- Outputs while in reset and in the first cycle after it:
  - `oOpcode`=`NOP`, `oOperand`=0, `oValid`=0, `oBr_taken`=0.
  - `oBr_dir`=0, `oPc`=`2^ADDR_W-1`.
- Reset asserted mid-SQUASH or mid-branch:
  - It overrides everything; the next state is SQUASH with `rInst`=`NOP`.
  - `oBr_taken` drops in the cycle after the reset edge.
- Latency:
  - Instruction at PC=k reaches `oOpcode` one cycle after fetch presents it.
  - A taken branch in decode at cycle t loads fetch's PC at edge t+1.
  - The target instruction appears in decode at cycle t+2.
  - Branch penalty is exactly 1 bubble.
- `oBr_taken`, `oBr_dir`, `oValid`, `oOpcode` and `oOperand` are combinational from registered state and flags. No path runs from `iFetchedInst` to any output within a cycle.

## Test plan
- Reset hold: `reset`=0 for 3 cycles with arbitrary `iFetchedInst` → `oValid`=0, `oBr_taken`=0, `oOpcode`=`NOP` every cycle; the first valid output appears in the second cycle after release.
- Straight-line stream:
  - Feed {`LDCA`,2'b00,8'h05} at PC 0 and {`LDCB`,2'b00,8'h07} at PC 1.
  - Expect `oOpcode`=`LDCA`, `oOperand`=10'h005, `oPc`=0, then `LDCB`/10'h007/`oPc`=1, with `oValid`=1 and `oBr_taken`=0.
- Taken conditional:
  - {`BACS`,4'b0,6'd50} at PC 15 with `iFlagsA`=3'b001.
  - Expect `oBr_taken`=1, `oBr_dir`=50 for one cycle, then one cycle with `oValid`=0, then `oPc`=50 with `oValid`=1.
- Not-taken conditional: same instruction with `iFlagsA`=3'b000 → `oBr_taken`=0; PC 16 follows with no bubble.
- Squash ignores a branch: a `JMP` 10'h020 arriving as the wrong-path instruction after a taken branch → `oBr_taken` stays 0 during SQUASH and fetch follows the first target.
- Back-to-back and wrap:
  - A `JMP` to 10'h3FF whose target holds `JMP` 10'h000 → two taken branches separated by exactly one bubble, and `oPc` reads 10'h3FF then 0.
  - Reset asserted during the second branch → `oBr_taken`=0 in the cycle after the reset edge.
